// File: rtl/window_extrema_if.sv
// ---------------------------------------------------------------------------
// window_extrema_if
//   Sample-in / result-out bundle for window_extrema_tracker.
//
//   Parameters
//     WIDTH   sample width (unsigned)
//     WINDOW  samples per window; sets the width of out_max_cnt
//
//   Signals
//     in_valid / in_ready / in_data      sample stream into the tracker
//     rel_valid / rel                    per-sample {gt,eq,lt} vs previous sample
//     out_valid / out_ready              window result handshake
//     out_max / out_min / out_max_cnt    window result payload
//
//   Modports
//     master  sample source + result consumer side
//     slave   the tracker itself
// ---------------------------------------------------------------------------
interface window_extrema_if #(
    parameter int WIDTH  = 4,
    parameter int WINDOW = 8
);
    localparam int CNT_W = $clog2(WINDOW + 1);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             rel_valid;
    logic [2:0]       rel;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_max;
    logic [WIDTH-1:0] out_min;
    logic [CNT_W-1:0] out_max_cnt;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  rel_valid,
        input  rel,
        input  out_valid,
        input  out_max,
        input  out_min,
        input  out_max_cnt
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output rel_valid,
        output rel,
        output out_valid,
        output out_max,
        output out_min,
        output out_max_cnt
    );
endinterface

// File: rtl/window_extrema_tracker.sv
// ---------------------------------------------------------------------------
// window_extrema_tracker
//   Consumes a valid/ready stream of unsigned samples. Each accepted sample is
//   compared against the running max, running min and the previous sample of
//   the current window. After WINDOW accepted samples the window's max, min and
//   the number of samples equal to max are presented on a valid/ready output
//   and held until the consumer takes them. While a result is pending no new
//   samples are accepted.
//
//   Ports
//     clk    in  rising-edge clock
//     rst_n  in  asynchronous reset, active-low
//     clear  in  synchronous flush of the partial window and any pending result
//     bus    window_extrema_if.slave (sample stream, rel output, result output)
//
//   Timing
//     rel_valid/rel      one cycle after each accept
//     out_valid          one cycle after the WINDOW-th accept
//     in_ready           decoded from registered state only (no path from out_ready)
// ---------------------------------------------------------------------------
module window_extrema_tracker #(
    parameter int WIDTH  = 4,
    parameter int WINDOW = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    window_extrema_if.slave   bus
);
    localparam int CNT_W = $clog2(WINDOW + 1);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t           state_reg;
    state_t           state_next;

    // Low during reset and for the first edge after release so in_ready
    // does not claim readiness while the block is still held in reset.
    logic             run_reg;

    // Running window state
    logic [CNT_W-1:0] count_reg;
    logic [WIDTH-1:0] max_reg;
    logic [WIDTH-1:0] min_reg;
    logic [WIDTH-1:0] prev_reg;
    logic [CNT_W-1:0] max_cnt_reg;

    // Next values of the running state for the sample currently offered
    logic [WIDTH-1:0] max_next;
    logic [WIDTH-1:0] min_next;
    logic [CNT_W-1:0] max_cnt_next;
    logic [2:0]       rel_next;

    // Registered per-sample relation
    logic             rel_valid_reg;
    logic [2:0]       rel_reg;

    // Registered window result, stable for the whole HOLD state
    logic [WIDTH-1:0] res_max_reg;
    logic [WIDTH-1:0] res_min_reg;
    logic [CNT_W-1:0] res_cnt_reg;

    logic             in_ready_w;
    logic             out_valid_w;
    logic             accept;
    logic             transfer;
    logic             first_sample;
    logic             last_sample;

    // ------------------------------------------------------------------
    // Handshake decode. clear masks both handshakes so that a same-cycle
    // sample is dropped and a same-cycle result transfer is not taken.
    // ------------------------------------------------------------------
    assign in_ready_w   = run_reg && (state_reg == ACCUM);
    assign out_valid_w  = (state_reg == HOLD);
    assign accept       = bus.in_valid && in_ready_w && !clear;
    assign transfer     = bus.out_ready && out_valid_w && !clear;
    assign first_sample = (count_reg == '0);
    assign last_sample  = (count_reg == CNT_W'(WINDOW - 1));

    // ------------------------------------------------------------------
    // Compare datapath (unsigned)
    // ------------------------------------------------------------------
    always_comb begin
        max_next     = max_reg;
        min_next     = min_reg;
        max_cnt_next = max_cnt_reg;
        rel_next     = 3'b000;

        if (first_sample) begin
            // A fresh window has no history: seed everything from the sample.
            max_next     = bus.in_data;
            min_next     = bus.in_data;
            max_cnt_next = CNT_W'(1);
            rel_next     = 3'b000;
        end else begin
            if (bus.in_data > max_reg) begin
                max_next     = bus.in_data;
                max_cnt_next = CNT_W'(1);
            end else if (bus.in_data == max_reg) begin
                max_cnt_next = max_cnt_reg + CNT_W'(1);
            end

            if (bus.in_data < min_reg) begin
                min_next = bus.in_data;
            end

            rel_next = {bus.in_data >  prev_reg,
                        bus.in_data == prev_reg,
                        bus.in_data <  prev_reg};
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ACCUM;
        end else begin
            state_reg <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        if (clear) begin
            state_next = ACCUM;
        end else begin
            case (state_reg)
                ACCUM: begin
                    if (accept && last_sample) begin
                        state_next = HOLD;
                    end
                end
                HOLD: begin
                    if (transfer) begin
                        state_next = ACCUM;
                    end
                end
                default: begin
                    state_next = ACCUM;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Running window state and sample counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_reg     <= 1'b0;
            count_reg   <= '0;
            max_reg     <= '0;
            min_reg     <= '0;
            prev_reg    <= '0;
            max_cnt_reg <= '0;
        end else begin
            run_reg <= 1'b1;
            if (clear) begin
                count_reg <= '0;
            end else if (accept) begin
                // Counter wraps on the closing sample, so the next window
                // starts from zero once the result has been taken.
                count_reg   <= last_sample ? '0 : count_reg + CNT_W'(1);
                max_reg     <= max_next;
                min_reg     <= min_next;
                prev_reg    <= bus.in_data;
                max_cnt_reg <= max_cnt_next;
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-sample relation output
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rel_valid_reg <= 1'b0;
            rel_reg       <= 3'b000;
        end else begin
            rel_valid_reg <= accept;
            if (accept) begin
                rel_reg <= rel_next;
            end
        end
    end

    // ------------------------------------------------------------------
    // Window result capture: loaded from the updated running values on the
    // closing accept, untouched otherwise so HOLD sees stable outputs.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_max_reg <= '0;
            res_min_reg <= '0;
            res_cnt_reg <= '0;
        end else if (accept && last_sample) begin
            res_max_reg <= max_next;
            res_min_reg <= min_next;
            res_cnt_reg <= max_cnt_next;
        end
    end

    // ------------------------------------------------------------------
    // Output drive
    // ------------------------------------------------------------------
    assign bus.in_ready    = in_ready_w;
    assign bus.out_valid   = out_valid_w;
    assign bus.rel_valid   = rel_valid_reg;
    assign bus.rel         = rel_reg;
    assign bus.out_max     = res_max_reg;
    assign bus.out_min     = res_min_reg;
    assign bus.out_max_cnt = res_cnt_reg;

endmodule

// File: tb/tb_window_extrema_tracker.sv
// ---------------------------------------------------------------------------
// tb_window_extrema_tracker
//   Directed bench for window_extrema_tracker. One instance with WINDOW=4 and
//   one with WINDOW=1 share clock, reset and clear. Inputs are driven and
//   outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_window_extrema_tracker;

    logic clk;
    logic rst_n;
    logic clear;

    int tests;
    int failed;

    window_extrema_if #(.WIDTH(4), .WINDOW(4)) a ();
    window_extrema_if #(.WIDTH(4), .WINDOW(1)) b ();

    window_extrema_tracker #(.WIDTH(4), .WINDOW(4)) u_w4 (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .bus   (a)
    );

    window_extrema_tracker #(.WIDTH(4), .WINDOW(1)) u_w1 (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .bus   (b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Offer one sample to the WINDOW=4 instance and check the relation it reports.
    task automatic push4(input string tag, input logic [3:0] d, input logic [2:0] er);
        chk({tag, "_in_ready"}, 32'(a.in_ready), 32'd1);
        a.in_valid = 1'b1;
        a.in_data  = d;
        @(negedge clk);
        a.in_valid = 1'b0;
        chk({tag, "_rel_valid"}, 32'(a.rel_valid), 32'd1);
        chk({tag, "_rel"}, 32'(a.rel), 32'(er));
        $display("[TB] %s sample=%0h rel=%b", tag, d, a.rel);
    endtask

    task automatic check_res4(input string tag, input logic [3:0] emax,
                              input logic [3:0] emin, input logic [2:0] ecnt);
        chk({tag, "_out_valid"}, 32'(a.out_valid), 32'd1);
        chk({tag, "_in_ready_hold"}, 32'(a.in_ready), 32'd0);
        chk({tag, "_max"}, 32'(a.out_max), 32'(emax));
        chk({tag, "_min"}, 32'(a.out_min), 32'(emin));
        chk({tag, "_cnt"}, 32'(a.out_max_cnt), 32'(ecnt));
        $display("[TB] %s result max=%0h min=%0h cnt=%0d", tag, a.out_max, a.out_min, a.out_max_cnt);
    endtask

    task automatic take4(input string tag);
        a.out_ready = 1'b1;
        @(negedge clk);
        a.out_ready = 1'b0;
        chk({tag, "_valid_dropped"}, 32'(a.out_valid), 32'd0);
        chk({tag, "_ready_back"}, 32'(a.in_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        tests       = 0;
        failed      = 0;
        rst_n       = 1'b0;
        clear       = 1'b0;
        a.in_valid  = 1'b0;
        a.in_data   = '0;
        a.out_ready = 1'b0;
        b.in_valid  = 1'b0;
        b.in_data   = '0;
        b.out_ready = 1'b0;

        // ---------------- reset state ----------------
        @(negedge clk);
        @(negedge clk);
        chk("rst_out_valid", 32'(a.out_valid), 32'd0);
        chk("rst_rel_valid", 32'(a.rel_valid), 32'd0);
        chk("rst_rel", 32'(a.rel), 32'd0);
        chk("rst_out_max", 32'(a.out_max), 32'd0);
        chk("rst_out_min", 32'(a.out_min), 32'd0);
        chk("rst_out_cnt", 32'(a.out_max_cnt), 32'd0);
        chk("rst_in_ready", 32'(a.in_ready), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_in_ready_a", 32'(a.in_ready), 32'd1);
        chk("rel_in_ready_b", 32'(b.in_ready), 32'd1);
        $display("[TB] reset released");

        // ---------------- 1: 3,9,9,1 with out_ready held ----------------
        a.out_ready = 1'b1;
        push4("t1_s0", 4'd3, 3'b000);
        push4("t1_s1", 4'd9, 3'b100);
        push4("t1_s2", 4'd9, 3'b010);
        push4("t1_s3", 4'd1, 3'b001);
        check_res4("t1", 4'd9, 4'd1, 3'd2);
        @(negedge clk);
        a.out_ready = 1'b0;
        chk("t1_one_cycle", 32'(a.out_valid), 32'd0);
        chk("t1_ready_back", 32'(a.in_ready), 32'd1);

        // ---------------- 2: unsigned compare ----------------
        push4("t2_s0", 4'd15, 3'b000);
        push4("t2_s1", 4'd0,  3'b001);
        push4("t2_s2", 4'd8,  3'b100);
        push4("t2_s3", 4'd15, 3'b100);
        check_res4("t2", 4'd15, 4'd0, 3'd2);
        take4("t2");

        // ---------------- 3: all equal ----------------
        push4("t3_s0", 4'd5, 3'b000);
        push4("t3_s1", 4'd5, 3'b010);
        push4("t3_s2", 4'd5, 3'b010);
        push4("t3_s3", 4'd5, 3'b010);
        check_res4("t3", 4'd5, 4'd5, 3'd4);
        take4("t3");

        // ---------------- 4: backpressure ----------------
        push4("t4_s0", 4'd2, 3'b000);
        push4("t4_s1", 4'd7, 3'b100);
        push4("t4_s2", 4'd4, 3'b001);
        push4("t4_s3", 4'd7, 3'b100);
        check_res4("t4", 4'd7, 4'd2, 3'd2);
        for (int i = 0; i < 3; i++) begin
            // A sample offered while the result is pending must be refused.
            a.in_valid = 1'b1;
            a.in_data  = 4'd1;
            @(negedge clk);
            chk("t4_hold_valid", 32'(a.out_valid), 32'd1);
            chk("t4_hold_in_ready", 32'(a.in_ready), 32'd0);
            chk("t4_hold_no_rel", 32'(a.rel_valid), 32'd0);
            chk("t4_hold_max", 32'(a.out_max), 32'd7);
            chk("t4_hold_min", 32'(a.out_min), 32'd2);
            chk("t4_hold_cnt", 32'(a.out_max_cnt), 32'd2);
            $display("[TB] t4 hold cycle %0d out_valid=%0d in_ready=%0d", i, a.out_valid, a.in_ready);
        end
        a.in_valid = 1'b0;
        take4("t4");

        // ---------------- 5a: reset mid-window ----------------
        push4("t5a_s0", 4'd6, 3'b000);
        push4("t5a_s1", 4'd1, 3'b001);
        rst_n = 1'b0;
        #1;
        chk("t5a_rst_rel_valid", 32'(a.rel_valid), 32'd0);
        chk("t5a_rst_out_valid", 32'(a.out_valid), 32'd0);
        chk("t5a_rst_in_ready", 32'(a.in_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("t5a_ready_after", 32'(a.in_ready), 32'd1);
        push4("t5a_s2", 4'd4, 3'b000);
        push4("t5a_s3", 4'd4, 3'b010);
        push4("t5a_s4", 4'd2, 3'b001);
        chk("t5a_no_early_result", 32'(a.out_valid), 32'd0);
        push4("t5a_s5", 4'd8, 3'b100);
        check_res4("t5a", 4'd8, 4'd2, 3'd1);
        take4("t5a");

        // ---------------- 5b: clear mid-window ----------------
        push4("t5b_s0", 4'd6, 3'b000);
        push4("t5b_s1", 4'd1, 3'b001);
        clear      = 1'b1;
        a.in_valid = 1'b1;
        a.in_data  = 4'd15;
        @(negedge clk);
        clear      = 1'b0;
        a.in_valid = 1'b0;
        chk("t5b_clr_rel_valid", 32'(a.rel_valid), 32'd0);
        chk("t5b_clr_out_valid", 32'(a.out_valid), 32'd0);
        chk("t5b_clr_in_ready", 32'(a.in_ready), 32'd1);
        push4("t5b_s2", 4'd4, 3'b000);
        push4("t5b_s3", 4'd4, 3'b010);
        push4("t5b_s4", 4'd2, 3'b001);
        chk("t5b_no_early_result", 32'(a.out_valid), 32'd0);
        push4("t5b_s5", 4'd8, 3'b100);
        check_res4("t5b", 4'd8, 4'd2, 3'd1);
        take4("t5b");

        // ---------------- 6: WINDOW=1, in_valid held high ----------------
        b.in_valid  = 1'b1;
        b.in_data   = 4'h3;
        b.out_ready = 1'b0;
        @(negedge clk);
        chk("t6_r0_valid", 32'(b.out_valid), 32'd1);
        chk("t6_r0_in_ready", 32'(b.in_ready), 32'd0);
        chk("t6_r0_max", 32'(b.out_max), 32'h3);
        chk("t6_r0_min", 32'(b.out_min), 32'h3);
        chk("t6_r0_cnt", 32'(b.out_max_cnt), 32'd1);
        chk("t6_r0_rel_valid", 32'(b.rel_valid), 32'd1);
        chk("t6_r0_rel", 32'(b.rel), 32'd0);
        $display("[TB] t6 result0 max=%0h min=%0h cnt=%0d", b.out_max, b.out_min, b.out_max_cnt);
        b.in_data = 4'hA;
        @(negedge clk);
        chk("t6_r0_held", 32'(b.out_valid), 32'd1);
        chk("t6_r0_held_max", 32'(b.out_max), 32'h3);
        chk("t6_r0_no_rel", 32'(b.rel_valid), 32'd0);
        b.out_ready = 1'b1;
        @(negedge clk);
        b.out_ready = 1'b0;
        chk("t6_gap_valid", 32'(b.out_valid), 32'd0);
        chk("t6_gap_in_ready", 32'(b.in_ready), 32'd1);
        @(negedge clk);
        chk("t6_r1_valid", 32'(b.out_valid), 32'd1);
        chk("t6_r1_max", 32'(b.out_max), 32'hA);
        chk("t6_r1_min", 32'(b.out_min), 32'hA);
        chk("t6_r1_cnt", 32'(b.out_max_cnt), 32'd1);
        chk("t6_r1_rel", 32'(b.rel), 32'd0);
        $display("[TB] t6 result1 max=%0h min=%0h cnt=%0d", b.out_max, b.out_min, b.out_max_cnt);
        b.in_valid  = 1'b0;
        b.out_ready = 1'b1;
        @(negedge clk);
        b.out_ready = 1'b0;
        chk("t6_r1_taken", 32'(b.out_valid), 32'd0);
        chk("t6_idle_in_ready", 32'(b.in_ready), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
